// File: rtl/mem_stage.sv
// Memory-access pipeline stage between ex/mem and mem/wb.
// Non-memory ops pass straight through; loads/stores run one data-bus
// transaction (req/ack) while the stage stalls the upstream pipeline.
// Handles MIPS big-endian lane selection, load extension and alignment.
module mem_stage #(
  parameter int unsigned BUS_TIMEOUT = 16  // legal range 2..255
) (
  input  logic        clk,
  input  logic        rst,
  // from ex/mem
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  // to mem/wb
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic        stall_req,
  output logic [1:0]  mem_exc,
  // data bus
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;

  localparam logic [7:0] CNT_LAST = 8'(BUS_TIMEOUT - 1);

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ALIGN   = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        timed_out_q, timed_out_d;
  logic [31:0] rdata_q, rdata_d;

  logic        is_load, is_store, sign_ext;
  size_t       size;
  logic        misaligned, aligned_mem;
  logic [3:0]  lane_sel;
  logic [31:0] store_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  // Opcode decode: access kind, size and extension mode.
  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sign_ext = 1'b0;
    size     = SZ_WORD;
    case (ex_aluop)
      OP_LB:  begin is_load  = 1'b1; size = SZ_BYTE; sign_ext = 1'b1; end
      OP_LH:  begin is_load  = 1'b1; size = SZ_HALF; sign_ext = 1'b1; end
      OP_LW:  begin is_load  = 1'b1; size = SZ_WORD; end
      OP_LBU: begin is_load  = 1'b1; size = SZ_BYTE; end
      OP_LHU: begin is_load  = 1'b1; size = SZ_HALF; end
      OP_SB:  begin is_store = 1'b1; size = SZ_BYTE; end
      OP_SH:  begin is_store = 1'b1; size = SZ_HALF; end
      OP_SW:  begin is_store = 1'b1; size = SZ_WORD; end
      default: ;
    endcase
  end

  // Big-endian byte lanes, replicated store data and alignment check.
  always_comb begin
    lane_sel   = 4'b1111;
    store_data = ex_reg2;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        lane_sel   = 4'b1000 >> ex_mem_addr[1:0];
        store_data = {4{ex_reg2[7:0]}};
      end
      SZ_HALF: begin
        lane_sel   = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
        store_data = {2{ex_reg2[15:0]}};
        misaligned = ex_mem_addr[0];
      end
      default: begin
        lane_sel   = 4'b1111;
        store_data = ex_reg2;
        misaligned = (ex_mem_addr[1:0] != 2'b00);
      end
    endcase
    misaligned  = misaligned & (is_load | is_store);
    aligned_mem = (is_load | is_store) & ~misaligned;
  end

  // Extract the addressed lane from the captured read word and extend it.
  always_comb begin
    case (ex_mem_addr[1:0])
      2'b00:   load_byte = rdata_q[31:24];
      2'b01:   load_byte = rdata_q[23:16];
      2'b10:   load_byte = rdata_q[15:8];
      default: load_byte = rdata_q[7:0];
    endcase
    load_half = ex_mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & load_byte[7]}}, load_byte};
      SZ_HALF: load_data = {{16{sign_ext & load_half[15]}}, load_half};
      default: load_data = rdata_q;
    endcase
  end

  // Next-state logic: transaction progress, timeout counting, data capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timed_out_d = timed_out_q;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (aligned_mem) begin
          if (bus_ack) begin
            rdata_d = bus_rdata;
            state_d = S_DONE;
          end else begin
            cnt_d   = 8'd1;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (bus_ack) begin
          rdata_d = bus_rdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timed_out_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d       = 8'd0;
        timed_out_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      timed_out_q <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
      rdata_q     <= rdata_d;
    end
  end

  // Output decode: pass-through, bubble while on the bus, writeback in DONE;
  // everything is held at zero while rst is high.
  always_comb begin
    mem_wd    = 5'd0;
    mem_wreg  = 1'b0;
    mem_wdata = 32'd0;
    mem_hi    = 32'd0;
    mem_lo    = 32'd0;
    mem_whilo = 1'b0;
    stall_req = 1'b0;
    mem_exc   = EXC_NONE;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
    bus_sel   = 4'd0;
    bus_wdata = 32'd0;
    if (!rst) begin
      mem_wd    = ex_wd;
      mem_wdata = ex_wdata;
      mem_hi    = ex_hi;
      mem_lo    = ex_lo;
      case (state_q)
        S_IDLE: begin
          if (misaligned) begin
            mem_exc = EXC_ALIGN;
          end else if (!aligned_mem) begin
            mem_wreg  = ex_wreg;
            mem_whilo = ex_whilo;
          end
        end
        S_DONE: begin
          mem_whilo = ex_whilo;
          if (timed_out_q) begin
            mem_wdata = 32'd0;
            mem_exc   = EXC_TIMEOUT;
          end else if (is_load) begin
            mem_wreg  = ex_wreg;
            mem_wdata = load_data;
          end
        end
        default: ;
      endcase
      // Bus is driven straight from ex_* while a request is outstanding.
      if ((state_q == S_IDLE && aligned_mem) || state_q == S_ACCESS) begin
        stall_req = 1'b1;
        bus_req   = 1'b1;
        bus_we    = is_store;
        bus_addr  = {ex_mem_addr[31:2], 2'b00};
        bus_sel   = lane_sel;
        bus_wdata = store_data;
      end
    end
  end

endmodule
